// File: rtl/paula_audio_mixer_seq.sv
// ---------------------------------------------------------------------------
// paula_audio_mixer_seq
//
// Four-channel audio mixer built around a single shared 8x7 signed-by-unsigned
// multiplier. A free-running six-step sequencer takes a snapshot of all inputs,
// multiplies each channel by its volume in turn, sums the two channels of each
// side, and publishes both side sums on the same edge.
//
// Ports
//   clk              bus clock, every state change happens on its rising edge
//   reset_n          synchronous active-low reset
//   clk7_en          clock enable; the sequencer advances only when it is 1
//   sample0..3 [7:0] channel samples, two's complement
//   vol0..3    [6:0] channel volumes, unsigned; bit 6 set means full scale (64)
//   ldatasum  [14:0] left mix, two's complement
//   rdatasum  [14:0] right mix, two's complement
//   mix_valid        one-clk pulse in the cycle after ldatasum/rdatasum update
//   state_dbg  [2:0] current sequencer state (SNAP=0 .. OUT=5)
//
// Handshake: mix_valid is a valid-only strobe with no ready. It is high for
// exactly one clk cycle after an update; ldatasum/rdatasum hold their values
// until the next update, so a consumer may sample them at any time after the
// strobe.
//
// Parameter SWAP_LR: 0 -> channels 0,3 left and 1,2 right;
//                    1 -> channels 1,2 left and 0,3 right.
// ---------------------------------------------------------------------------
module paula_audio_mixer_seq #(
  parameter bit SWAP_LR = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic [7:0]  sample0,
  input  logic [7:0]  sample1,
  input  logic [7:0]  sample2,
  input  logic [7:0]  sample3,
  input  logic [6:0]  vol0,
  input  logic [6:0]  vol1,
  input  logic [6:0]  vol2,
  input  logic [6:0]  vol3,
  output logic [14:0] ldatasum,
  output logic [14:0] rdatasum,
  output logic        mix_valid,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_SNAP = 3'd0,
    ST_MULA = 3'd1,
    ST_MULB = 3'd2,
    ST_MULC = 3'd3,
    ST_MULD = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // Channel routing for each multiply step.
  localparam logic [1:0] CH_LA = SWAP_LR ? 2'd1 : 2'd0;
  localparam logic [1:0] CH_LB = SWAP_LR ? 2'd2 : 2'd3;
  localparam logic [1:0] CH_RA = SWAP_LR ? 2'd0 : 2'd1;
  localparam logic [1:0] CH_RB = SWAP_LR ? 2'd3 : 2'd2;

  state_t state;
  state_t state_next;

  // Snapshot of the inputs; the multiply steps read only these.
  logic [7:0] snap_sample [4];
  logic [6:0] snap_vol    [4];

  logic [14:0] acc_l;
  logic [14:0] acc_r;

  // Control decoded from the state (already qualified by clk7_en).
  logic       snap_en;
  logic       acc_l_load;
  logic       acc_l_add;
  logic       acc_r_load;
  logic       acc_r_add;
  logic       out_en;
  logic [1:0] mul_sel;

  // Shared multiplier datapath.
  logic [7:0]  mul_sample;
  logic [6:0]  mul_vol_raw;
  logic [6:0]  eff_vol;
  logic [13:0] mul_a;
  logic [13:0] mul_b;
  logic [13:0] product;
  logic [14:0] product_ext;

  // -------------------------------------------------------------------------
  // Sequencer: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_SNAP;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer: next-state logic (free-running ring, advances on enable only)
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (clk7_en) begin
      unique case (state)
        ST_SNAP: state_next = ST_MULA;
        ST_MULA: state_next = ST_MULB;
        ST_MULB: state_next = ST_MULC;
        ST_MULC: state_next = ST_MULD;
        ST_MULD: state_next = ST_OUT;
        ST_OUT:  state_next = ST_SNAP;
        default: state_next = ST_SNAP;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer: output decode
  // -------------------------------------------------------------------------
  always_comb begin
    snap_en    = 1'b0;
    acc_l_load = 1'b0;
    acc_l_add  = 1'b0;
    acc_r_load = 1'b0;
    acc_r_add  = 1'b0;
    out_en     = 1'b0;
    mul_sel    = CH_LA;
    unique case (state)
      ST_SNAP: snap_en = clk7_en;
      ST_MULA: begin
        mul_sel    = CH_LA;
        acc_l_load = clk7_en;
      end
      ST_MULB: begin
        mul_sel   = CH_LB;
        acc_l_add = clk7_en;
      end
      ST_MULC: begin
        mul_sel    = CH_RA;
        acc_r_load = clk7_en;
      end
      ST_MULD: begin
        mul_sel   = CH_RB;
        acc_r_add = clk7_en;
      end
      ST_OUT:  out_en = clk7_en;
      default: ;
    endcase
  end

  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Input snapshot
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        snap_sample[i] <= '0;
        snap_vol[i]    <= '0;
      end
    end else if (snap_en) begin
      snap_sample[0] <= sample0;
      snap_sample[1] <= sample1;
      snap_sample[2] <= sample2;
      snap_sample[3] <= sample3;
      snap_vol[0]    <= vol0;
      snap_vol[1]    <= vol1;
      snap_vol[2]    <= vol2;
      snap_vol[3]    <= vol3;
    end
  end

  // -------------------------------------------------------------------------
  // Shared multiplier. Volume bit 6 forces full scale (64) regardless of the
  // low bits. Operands are widened to the 14-bit product width: the sample is
  // sign-extended, the volume zero-extended, so the low 14 bits of the
  // product are the exact signed result (-8192..+8128 fits).
  // -------------------------------------------------------------------------
  always_comb begin
    mul_sample  = snap_sample[mul_sel];
    mul_vol_raw = snap_vol[mul_sel];
    eff_vol     = mul_vol_raw[6] ? 7'd64 : {1'b0, mul_vol_raw[5:0]};
    mul_a       = {{6{mul_sample[7]}}, mul_sample};
    mul_b       = {7'd0, eff_vol};
    product     = mul_a * mul_b;
    product_ext = {product[13], product};
  end

  // -------------------------------------------------------------------------
  // Side accumulators. Each side is two products, so 15 bits cannot overflow.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      if (acc_l_load) begin
        acc_l <= product_ext;
      end else if (acc_l_add) begin
        acc_l <= acc_l + product_ext;
      end
      if (acc_r_load) begin
        acc_r <= product_ext;
      end else if (acc_r_add) begin
        acc_r <= acc_r + product_ext;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output registers. Both sums are published on the same edge, and the
  // strobe follows in the next cycle. Since OUT is always followed by SNAP,
  // mix_valid can never stay high for two cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ldatasum  <= '0;
      rdatasum  <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= out_en;
      if (out_en) begin
        ldatasum <= acc_l;
        rdatasum <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_paula_audio_mixer_seq.sv
// ---------------------------------------------------------------------------
// tb_paula_audio_mixer_seq
//
// Directed bench for paula_audio_mixer_seq. Two instances share the stimulus:
// dut (SWAP_LR=0) and dut_sw (SWAP_LR=1). Inputs are driven #1 after the
// rising edge and outputs are checked at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_paula_audio_mixer_seq;

  logic        clk;
  logic        reset_n;
  logic        clk7_en;
  logic [7:0]  sample0, sample1, sample2, sample3;
  logic [6:0]  vol0, vol1, vol2, vol3;
  logic [14:0] ldatasum, rdatasum;
  logic        mix_valid;
  logic [2:0]  state_dbg;
  logic [14:0] sw_ldatasum, sw_rdatasum;
  logic        sw_mix_valid;
  logic [2:0]  sw_state_dbg;

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  paula_audio_mixer_seq #(.SWAP_LR(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk7_en   (clk7_en),
    .sample0   (sample0),
    .sample1   (sample1),
    .sample2   (sample2),
    .sample3   (sample3),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ldatasum  (ldatasum),
    .rdatasum  (rdatasum),
    .mix_valid (mix_valid),
    .state_dbg (state_dbg)
  );

  paula_audio_mixer_seq #(.SWAP_LR(1'b1)) dut_sw (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk7_en   (clk7_en),
    .sample0   (sample0),
    .sample1   (sample1),
    .sample2   (sample2),
    .sample3   (sample3),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .ldatasum  (sw_ldatasum),
    .rdatasum  (sw_rdatasum),
    .mix_valid (sw_mix_valid),
    .state_dbg (sw_state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] s0, input logic [6:0] v0,
                            input logic [7:0] s1, input logic [6:0] v1,
                            input logic [7:0] s2, input logic [6:0] v2,
                            input logic [7:0] s3, input logic [6:0] v3);
    sample0 = s0; vol0 = v0;
    sample1 = s1; vol1 = v1;
    sample2 = s2; vol2 = v2;
    sample3 = s3; vol3 = v3;
  endtask

  // One reset edge, then released with the sequencer sitting in SNAP.
  task automatic do_reset();
    reset_n = 1'b0;
    clk7_en = 1'b1;
    tick();
    reset_n = 1'b1;
  endtask

  // Runs n enabled cycles; returns how many mix_valid pulses were seen.
  task automatic run_enables(input int n, output int pulses);
    pulses = 0;
    clk7_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mix_valid === 1'b1) pulses++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_inputs(8'h55, 7'h3F, 8'hAA, 7'h40, 8'h12, 7'h11, 8'h7F, 7'h7F);
    reset_n = 1'b0;
    clk7_en = 1'b0;
    tick();
    checks++; if (ldatasum !== 15'd0) begin errors++; $display("FAIL reset_ldatasum got=%0h exp=0", ldatasum); end
    checks++; if (rdatasum !== 15'd0) begin errors++; $display("FAIL reset_rdatasum got=%0h exp=0", rdatasum); end
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL reset_mix_valid got=%b exp=0", mix_valid); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_left_full();
    int pulses;
    set_inputs(8'h7F, 7'd64, 8'h00, 7'd0, 8'h00, 7'd0, 8'h7F, 7'd64);
    do_reset();
    run_enables(5, pulses);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL left_full_early_valid got=%0d exp=0", pulses); end
    tick();
    checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL left_full_valid got=%b exp=1", mix_valid); end
    checks++; if (ldatasum !== 15'h3F80) begin errors++; $display("FAIL left_full_l got=%0h exp=3f80", ldatasum); end
    checks++; if (rdatasum !== 15'd0) begin errors++; $display("FAIL left_full_r got=%0h exp=0", rdatasum); end
    checks++; if (sw_rdatasum !== 15'h3F80) begin errors++; $display("FAIL swap_full_r got=%0h exp=3f80", sw_rdatasum); end
    checks++; if (sw_ldatasum !== 15'd0) begin errors++; $display("FAIL swap_full_l got=%0h exp=0", sw_ldatasum); end
    tick();
    checks++; if (mix_valid !== 1'b0) begin errors++; $display("FAIL left_full_valid_width got=%b exp=0", mix_valid); end
  endtask

  task automatic test_vol_clamp();
    int pulses;
    set_inputs(8'h00, 7'd0, 8'h80, 7'h7F, 8'h80, 7'h7F, 8'h00, 7'd0);
    do_reset();
    run_enables(6, pulses);
    checks++; if (pulses !== 1 || mix_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid got=%0d exp=1", pulses); end
    checks++; if (rdatasum !== 15'h4000) begin errors++; $display("FAIL clamp_r got=%0h exp=4000", rdatasum); end
    checks++; if (ldatasum !== 15'd0) begin errors++; $display("FAIL clamp_l got=%0h exp=0", ldatasum); end
  endtask

  task automatic test_sparse_enable();
    int bad_valid;
    int bad_hold;
    logic [14:0] prev_l;
    logic [14:0] prev_r;
    set_inputs(8'h10, 7'd8, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    do_reset();
    bad_valid = 0;
    bad_hold  = 0;
    for (int c = 0; c < 24; c++) begin
      prev_l  = ldatasum;
      prev_r  = rdatasum;
      clk7_en = ((c % 4) == 0);
      tick();
      if (c == 20) begin
        checks++; if (mix_valid !== 1'b1) begin errors++; $display("FAIL sparse_valid got=%b exp=1", mix_valid); end
        checks++; if (ldatasum !== 15'd128) begin errors++; $display("FAIL sparse_l got=%0d exp=128", ldatasum); end
      end else begin
        if (mix_valid !== 1'b0) bad_valid++;
      end
      if ((c % 4) != 0 && (ldatasum !== prev_l || rdatasum !== prev_r)) bad_hold++;
    end
    checks++; if (bad_valid !== 0) begin errors++; $display("FAIL sparse_stray_valid got=%0d exp=0", bad_valid); end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL sparse_hold got=%0d exp=0", bad_hold); end
    // long idle stretch: everything holds
    clk7_en = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checks++; if (ldatasum !== 15'd128 || mix_valid !== 1'b0) begin errors++; $display("FAIL idle_hold got=%0d/%b exp=128/0", ldatasum, mix_valid); end
  endtask

  task automatic test_snapshot();
    int pulses;
    set_inputs(8'h01, 7'd1, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    do_reset();
    run_enables(2, pulses);  // SNAP, MULA edges: now in MULB
    checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL snap_state got=%0d exp=2", state_dbg); end
    sample0 = 8'h7F;
    run_enables(4, pulses);
    checks++; if (ldatasum !== 15'd1 || mix_valid !== 1'b1) begin errors++; $display("FAIL snap_frame1 got=%0d/%b exp=1/1", ldatasum, mix_valid); end
    run_enables(6, pulses);  // back to back frame
    checks++; if (ldatasum !== 15'd127 || pulses !== 1) begin errors++; $display("FAIL snap_frame2 got=%0d/%0d exp=127/1", ldatasum, pulses); end
  endtask

  task automatic test_midframe_reset();
    int pulses;
    set_inputs(8'h10, 7'd8, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    do_reset();
    run_enables(6, pulses);
    checks++; if (ldatasum !== 15'd128) begin errors++; $display("FAIL mid_pre got=%0d exp=128", ldatasum); end
    run_enables(3, pulses);  // SNAP, MULA, MULB: now in MULC
    reset_n = 1'b0;
    tick();
    checks++; if (ldatasum !== 15'd0 || rdatasum !== 15'd0) begin errors++; $display("FAIL mid_clear got=%0d/%0d exp=0/0", ldatasum, rdatasum); end
    checks++; if (state_dbg !== 3'd0 || mix_valid !== 1'b0) begin errors++; $display("FAIL mid_state got=%0d/%b exp=0/0", state_dbg, mix_valid); end
    reset_n = 1'b1;
    run_enables(5, pulses);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_early_valid got=%0d exp=0", pulses); end
    tick();
    checks++; if (mix_valid !== 1'b1 || ldatasum !== 15'd128) begin errors++; $display("FAIL mid_first got=%b/%0d exp=1/128", mix_valid, ldatasum); end
  endtask

  task automatic test_zero_and_signed();
    int pulses;
    logic [14:0] exp_r;
    // zero volumes with busy samples
    set_inputs(8'h7F, 7'd0, 8'h80, 7'd0, 8'h33, 7'd0, 8'hC5, 7'd0);
    do_reset();
    run_enables(6, pulses);
    checks++; if (ldatasum !== 15'd0 || rdatasum !== 15'd0) begin errors++; $display("FAIL zero_vol got=%0d/%0d exp=0/0", ldatasum, rdatasum); end
    // zero samples with busy volumes
    set_inputs(8'h00, 7'h7F, 8'h00, 7'd33, 8'h00, 7'd64, 8'h00, 7'd5);
    run_enables(6, pulses);
    checks++; if (ldatasum !== 15'd0 || rdatasum !== 15'd0) begin errors++; $display("FAIL zero_smp got=%0d/%0d exp=0/0", ldatasum, rdatasum); end
    // mixed signs: left = -1*1 + 2*3 = 5; right = -64*64 + 5*10 = -4046
    set_inputs(8'hFF, 7'd1, 8'hC0, 7'h45, 8'h05, 7'd10, 8'h02, 7'd3);
    exp_r = 15'h7FFF - 15'd4045;
    run_enables(6, pulses);
    checks++; if (ldatasum !== 15'd5) begin errors++; $display("FAIL signed_l got=%0d exp=5", ldatasum); end
    checks++; if (rdatasum !== exp_r) begin errors++; $display("FAIL signed_r got=%0h exp=%0h", rdatasum, exp_r); end
  endtask

  task automatic test_swap();
    int pulses;
    set_inputs(8'h40, 7'd32, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    do_reset();
    run_enables(6, pulses);
    checks++; if (sw_rdatasum !== 15'd2048 || sw_ldatasum !== 15'd0) begin errors++; $display("FAIL swap_r got=%0d/%0d exp=2048/0", sw_rdatasum, sw_ldatasum); end
    checks++; if (sw_mix_valid !== 1'b1) begin errors++; $display("FAIL swap_valid got=%b exp=1", sw_mix_valid); end
    checks++; if (ldatasum !== 15'd2048 || rdatasum !== 15'd0) begin errors++; $display("FAIL noswap_l got=%0d/%0d exp=2048/0", ldatasum, rdatasum); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    clk7_en = 1'b0;
    set_inputs(8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    test_reset();
    test_left_full();
    test_vol_clamp();
    test_sparse_enable();
    test_snapshot();
    test_midframe_reset();
    test_zero_and_signed();
    test_swap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paula_audio_mixer_seq.md
PAULA_AUDIO_MIXER_SEQ -- requirements
Module: paula_audio_mixer_seq

Interface
REQ-001 Parameter SWAP_LR, default 0: 0 = channels 0,3 drive left and 1,2 drive right; 1 = channels 1,2 drive left and 0,3 drive right.
REQ-002 clk  input  1  bus clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 clk7_en  input  1  clock enable; the block advances only in cycles with clk7_en=1.
REQ-005 sample0..sample3  input  8 each  channel sample, two's complement.
REQ-006 vol0..vol3  input  7 each  channel volume, unsigned, nominal 0..64.
REQ-007 ldatasum  output  15  left mix, two's complement; feeds the sigma-delta modulator.
REQ-008 rdatasum  output  15  right mix, two's complement.
REQ-009 mix_valid  output  1  one-clk pulse, high in the cycle after ldatasum/rdatasum update.

Function
REQ-010 Single shared 8x7 signed-by-unsigned multiplier, time-multiplexed across all four channels; no per-channel multipliers.
REQ-011 Effective volume = 64 when vol[6]=1, regardless of vol[5:0]; otherwise vol[5:0].
REQ-012 Product = sample x effective volume, 14-bit signed; range -8192..+8128.
REQ-013 Pair sum is sign-extended to 15 bits; range -16384..+16256; no saturation or clipping required.
REQ-014 Sequencer states, each advancing on one clk7_en: SNAP -> MULA -> MULB -> MULC -> MULD -> OUT -> SNAP, free-running.
REQ-015 SNAP: capture all eight sample/vol inputs into a snapshot register; later states use only the snapshot.
REQ-016 MULA: acc_l <= product(left ch A).
REQ-017 MULB: acc_l <= acc_l + product(left ch B).
REQ-018 MULC: acc_r <= product(right ch A).
REQ-019 MULD: acc_r <= acc_r + product(right ch B).
REQ-020 Channel A/B per side: SWAP_LR=0 -> left = (0,3), right = (1,2); SWAP_LR=1 -> left = (1,2), right = (0,3).
REQ-021 OUT: ldatasum <= acc_l and rdatasum <= acc_r in the same clk edge; both outputs are never updated on different edges.
REQ-022 mix_valid = 1 for exactly one clk cycle following the OUT-state edge, even if clk7_en is still high; 0 otherwise.
REQ-023 Frame = 6 clk7_en cycles; outputs reflect inputs captured 5 enables earlier at SNAP.
REQ-024 Outputs are held constant between OUT updates, including during long clk7_en=0 stretches.
REQ-025 clk7_en=0: state, snapshot, accumulators and outputs hold; mix_valid=0.
REQ-026 Input changes between SNAP edges have no effect on the frame in progress.
REQ-027 All-zero volumes or samples -> outputs exactly 0; no DC offset is introduced.

Reset
REQ-028 reset_n=0 at a clk edge (clk7_en ignored): state <= SNAP, snapshot and accumulators <= 0, ldatasum = rdatasum = 0, mix_valid = 0.
REQ-029 Reset asserted mid-frame discards the partial frame; the first frame after release starts at SNAP.
REQ-030 First mix_valid after release occurs on the 6th clk7_en cycle after reset_n returns to 1 (clk7_en held high).

Verification
REQ-031 SWAP_LR=0, clk7_en=1, sample0=0x7F vol0=64, sample3=0x7F vol3=64, others 0 -> after 6 enables ldatasum=16256 (0x3F80), rdatasum=0, one mix_valid pulse.
REQ-032 sample1=sample2=0x80, vol1=vol2=0x7F -> vol clamps to 64, rdatasum=-16384 (0x4000); ldatasum=0.
REQ-033 clk7_en pulsed 1-in-4, sample0=0x10, vol0=8 -> ldatasum=128 after 6 enables (24 clks); outputs stable and mix_valid low between enables.
REQ-034 Change sample0 from 0x01 to 0x7F during MULB with vol0=1 -> that frame outputs ldatasum=1; next frame outputs 127.
REQ-035 reset_n pulsed low during MULC with nonzero mix present -> outputs 0 next edge; no mix_valid until 6 enables after release.
REQ-036 SWAP_LR=1, sample0=0x40 vol0=32, others 0 -> rdatasum=2048, ldatasum=0.
